pulse_window_counter: RTL and testbench

Downstream consumer of the shift-register counter's `count_pulse` output. It counts rising edges of `count_pulse` over a fixed window of `WINDOW` clock cycles while `enable` is high. At the end of each window it publishes the total to a single-entry output register with a valid/ready handshake. Windows that close while the previous result is still unaccepted are dropped and flagged.

---
 rtl/pulse_window_counter.sv | 106 ++++++++++
 tb/tb_pulse_window_counter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_window_counter.sv
// Counts rising edges of count_pulse over fixed WINDOW-cycle windows while enabled and
// publishes each total through a single-entry valid/ready register; results that cannot be stored are dropped.
module pulse_window_counter #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             count_pulse,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic {S_IDLE, S_COUNT} state_e;

    state_e             state_q;
    logic               pulse_q;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [WIN_W-1:0]   win_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_sat_q, out_valid_q, overrun_q, busy_q;
    logic               evt, win_last, accept;

    always_comb begin
        evt      = count_pulse & ~pulse_q;
        win_last = (win_q == WIN_LAST);
        accept   = out_valid_q & out_ready;
        acc_d    = acc_q + CNT_W'(evt);
        sat_d    = sat_q;
        // A full accumulator holds its value and remembers that an event was lost.
        if (evt && (&acc_q)) begin
            acc_d = acc_q;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pulse_q     <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            win_q       <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pulse_q   <= count_pulse;
            overrun_q <= 1'b0;
            if (accept)
                out_valid_q <= 1'b0;

            if (state_q == S_IDLE) begin
                if (enable) begin
                    state_q <= S_COUNT;
                    busy_q  <= 1'b1;
                    acc_q   <= '0;
                    sat_q   <= 1'b0;
                    win_q   <= '0;
                end
            end else begin
                if (!enable) begin
                    // Abort beats a coinciding window close: the partial window is discarded.
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    acc_q   <= '0;
                    sat_q   <= 1'b0;
                    win_q   <= '0;
                end else if (win_last) begin
                    acc_q <= '0;
                    sat_q <= 1'b0;
                    win_q <= '0;
                    if (!out_valid_q || out_ready) begin
                        out_count_q <= acc_d;
                        out_sat_q   <= sat_d;
                        out_valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end else begin
                    acc_q <= acc_d;
                    sat_q <= sat_d;
                    win_q <= win_q + 1'b1;
                end
            end
        end
    end

    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Scoreboard bench for pulse_window_counter: two widths (8 and 3 bits) share stimulus;
// a window-sample reference model predicts results, a negedge monitor compares them.
module tb_pulse_window_counter;

    localparam int WINDOW = 16;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, count_pulse = 1'b0, out_ready = 1'b0;
    logic [7:0] cnt8;
    logic       sat8, val8, ovr8, busy8;
    logic [2:0] cnt3;
    logic       sat3, val3, ovr3, busy3;

    always #5 clk = ~clk;

    pulse_window_counter #(.CNT_W(8), .WINDOW(WINDOW)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .count_pulse(count_pulse),
        .out_count(cnt8), .out_sat(sat8), .out_valid(val8), .out_ready(out_ready),
        .overrun(ovr8), .busy(busy8));

    pulse_window_counter #(.CNT_W(3), .WINDOW(WINDOW)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .count_pulse(count_pulse),
        .out_count(cnt3), .out_sat(sat3), .out_valid(val3), .out_ready(out_ready),
        .overrun(ovr3), .busy(busy3));

    typedef struct {
        int cnt;
        bit sat;
    } res_t;

    res_t exp8[$], exp3[$];
    bit   m_active, m_valid, m_ovr, m_prev, mdl_pub;
    bit   m_win[$];
    int   mdl_n;
    int   nchecks = 0, nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rising_edges(input bit prev0, input bit w[$]);
        int n = 0;
        bit p = prev0;
        foreach (w[i]) begin
            if (w[i] && !p) n++;
            p = w[i];
        end
        return n;
    endfunction

    function automatic res_t mk(input int n, input int width);
        res_t r;
        int mx = (1 << width) - 1;
        r.cnt = (n > mx) ? mx : n;
        r.sat = (n > mx);
        return r;
    endfunction

    // Reference model: keeps the raw samples of the current window and counts edges at its end.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            m_prev   = 1'b0;
            m_win.delete();
            exp8.delete();
            exp3.delete();
        end else begin
            mdl_pub = 1'b0;
            m_ovr   = 1'b0;
            mdl_n   = 0;
            if (!m_active) begin
                if (enable) begin
                    m_active = 1'b1;
                    m_prev   = count_pulse;
                    m_win.delete();
                end
            end else if (!enable) begin
                m_active = 1'b0;
                m_win.delete();
            end else begin
                m_win.push_back(count_pulse);
                if (m_win.size() == WINDOW) begin
                    mdl_n   = rising_edges(m_prev, m_win);
                    m_prev  = count_pulse;
                    m_win.delete();
                    mdl_pub = 1'b1;
                end
            end
            if (m_valid && out_ready) m_valid = 1'b0;
            if (mdl_pub) begin
                if (!m_valid) begin
                    exp8.push_back(mk(mdl_n, 8));
                    exp3.push_back(mk(mdl_n, 3));
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    // Monitor: status every cycle, result contents whenever the consumer takes one.
    always @(negedge clk) begin
        res_t e;
        chk("busy8", busy8, m_active);
        chk("busy3", busy3, m_active);
        chk("valid8", val8, m_valid);
        chk("valid3", val3, m_valid);
        chk("overrun8", ovr8, m_ovr);
        chk("overrun3", ovr3, m_ovr);
        if (val8 && out_ready) begin
            if (exp8.size() == 0) chk("sb8_pending", exp8.size(), 1);
            else begin
                e = exp8.pop_front();
                chk("count8", cnt8, e.cnt);
                chk("sat8", sat8, e.sat);
            end
        end
        if (val3 && out_ready) begin
            if (exp3.size() == 0) chk("sb3_pending", exp3.size(), 1);
            else begin
                e = exp3.pop_front();
                chk("count3", cnt3, e.cnt);
                chk("sat3", sat3, e.sat);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Return to IDLE with the output register drained, then start a window at the next edge.
    task automatic fresh(input bit rdy);
        enable      = 1'b0;
        out_ready   = 1'b1;
        count_pulse = 1'b0;
        cyc(2);
        out_ready = rdy;
        enable    = 1'b1;
        cyc(1);
    endtask

    initial begin
        int rp;
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            count_pulse = ~count_pulse;
            cyc(1);
        end
        chk("rst_count", cnt8, 0);
        chk("rst_valid", val8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_overrun", ovr8, 0);
        chk("rst_sat", sat8, 0);
        rst_n       = 1'b1;
        count_pulse = 1'b0;
        cyc(2);

        fresh(1'b1);
        for (int i = 0; i < 48; i++) begin
            count_pulse = (i % 4 == 0);
            cyc(1);
            if (i == 15 || i == 31) begin
                chk("basic_count", cnt8, 4);
                chk("basic_valid", val8, 1);
            end
        end

        fresh(1'b0);
        for (int i = 0; i < 16; i++) begin
            count_pulse = (i >= 3 && i < 8);
            cyc(1);
        end
        chk("level_count", cnt8, 1);

        fresh(1'b0);
        for (int i = 0; i < 16; i++) begin
            count_pulse = (i == 1 || i == 5 || i == 9);
            cyc(1);
        end
        chk("bp_first", cnt8, 3);
        for (int i = 0; i < 16; i++) begin
            count_pulse = (i % 2 == 1 && i < 12);
            cyc(1);
        end
        chk("bp_overrun", ovr8, 1);
        chk("bp_hold", cnt8, 3);
        out_ready = 1'b1;
        cyc(1);
        chk("bp_accepted", val8, 0);

        fresh(1'b0);
        for (int i = 0; i < 16; i++) begin
            count_pulse = (i % 2 == 0);
            cyc(1);
        end
        chk("sat_count3", cnt3, 7);
        chk("sat_flag3", sat3, 1);
        chk("sat_count8", cnt8, 8);
        chk("sat_flag8", sat8, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            count_pulse = (i == 2 || i == 6);
            cyc(1);
        end
        chk("sat_next_count3", cnt3, 2);
        chk("sat_next_flag3", sat3, 0);

        fresh(1'b0);
        for (int i = 0; i < 9; i++) begin
            count_pulse = (i % 2 == 0);
            cyc(1);
        end
        enable      = 1'b0;
        count_pulse = 1'b0;
        cyc(1);
        chk("abort_busy", busy8, 0);
        chk("abort_valid", val8, 0);
        chk("abort_hold", cnt8, 2);
        enable = 1'b1;
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            count_pulse = (i == 4 || i == 8 || i == 12);
            cyc(1);
        end
        chk("reenable_count", cnt8, 3);

        cyc(4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", cnt8, 0);
        chk("midrst_valid", val8, 0);
        chk("midrst_busy", busy8, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0: rp = 100;
                1: rp = 50;
                2: rp = 10;
                3: rp = 0;
                4: rp = 80;
                default: rp = 30;
            endcase
            for (int i = 0; i < 300; i++) begin
                enable      = ($urandom_range(0, 149) != 0) || (enable && $urandom_range(0, 3) != 0 && seg == 5);
                count_pulse = ($urandom_range(0, 2) == 0);
                out_ready   = ($urandom_range(0, 99) < rp);
                cyc(1);
            end
        end

        enable    = 1'b0;
        out_ready = 1'b1;
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule
